// File: rtl/fft_sched_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : fft_sched_pkg                                                |
// | Description : Shared constants, types and helpers for the FFT readout      |
// |               scheduler (engine count, bin geometry, FSM state encoding).  |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
package fft_sched_pkg;

    localparam int NUM_FFT   = 4;
    localparam int BIN_COUNT = 512;
    localparam int ADDR_W    = 9;
    localparam int DATA_W    = 32;
    localparam int FFT_ID_W  = 2;
    localparam int SEQ_W     = 16;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_READ    = 2'd1,
        S_RELEASE = 2'd2
    } state_t;

    // One bin held in the output skid buffer
    typedef struct packed {
        logic [ADDR_W-1:0] bin;
        logic [DATA_W-1:0] data;
    } skid_entry_t;

    // Adds the number of set bits in hits to base, saturating at 255
    function automatic logic [7:0] sat_add8(input logic [7:0] base, input logic [NUM_FFT-1:0] hits);
        logic [8:0] sum;
        sum = {1'b0, base};
        for (int i = 0; i < NUM_FFT; i++) begin
            sum = sum + {8'd0, hits[i]};
        end
        return (sum > 9'd255) ? 8'hFF : sum[7:0];
    endfunction

endpackage
`default_nettype wire

// File: rtl/fft_readout_scheduler_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : fft_readout_scheduler_if                                     |
// | Description : Valid/ready bin stream from the readout scheduler to the     |
// |               spectral (peak/fingerprint) stage.                           |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
interface fft_readout_scheduler_if;
    import fft_sched_pkg::*;

    logic                out_valid;
    logic                out_ready;
    logic [DATA_W-1:0]   out_data;
    logic [ADDR_W-1:0]   out_bin;
    logic                out_last;
    logic [FFT_ID_W-1:0] out_fft_id;
    logic [SEQ_W-1:0]    out_frame_seq;

    modport master (
        output out_valid,
        output out_data,
        output out_bin,
        output out_last,
        output out_fft_id,
        output out_frame_seq,
        input  out_ready
    );

    modport slave (
        input  out_valid,
        input  out_data,
        input  out_bin,
        input  out_last,
        input  out_fft_id,
        input  out_frame_seq,
        output out_ready
    );
endinterface
`default_nettype wire

// File: rtl/fft_order_queue.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : fft_order_queue                                              |
// | Description : Oldest-first FIFO of FFT engine IDs with a pending bitmap.   |
// |               Simultaneous dones are appended in ascending ID order; a     |
// |               done for an ID already pending is reported as dropped.       |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module fft_order_queue
    import fft_sched_pkg::*;
(
    input  wire                 clk,
    input  wire                 reset,
    input  wire  [NUM_FFT-1:0]  done,
    input  wire                 pop,
    output logic [FFT_ID_W-1:0] head_id,
    output logic                not_empty,
    output logic [NUM_FFT-1:0]  dropped
);

    logic [FFT_ID_W-1:0] entry      [NUM_FFT];
    logic [FFT_ID_W-1:0] entry_next [NUM_FFT];
    logic [FFT_ID_W:0]   count;
    logic [FFT_ID_W:0]   count_next;
    logic [NUM_FFT-1:0]  pending;
    logic [NUM_FFT-1:0]  pending_next;
    logic [NUM_FFT-1:0]  pop_mask;
    logic [NUM_FFT-1:0]  accept;

    assign head_id   = entry[0];
    assign not_empty = (count != '0);

    // The ID being popped this cycle no longer counts as pending, so a done
    // arriving together with its release is taken as a fresh frame
    always_comb begin
        pop_mask = '0;
        if (pop && not_empty) begin
            pop_mask[head_id] = 1'b1;
        end
    end

    assign accept  = done & ~(pending & ~pop_mask);
    assign dropped = done & ~accept;

    // Next queue contents: shift out the head on pop, then append accepted IDs low to high
    always_comb begin
        entry_next   = entry;
        count_next   = count;
        pending_next = pending & ~pop_mask;
        if (pop && not_empty) begin
            for (int k = 0; k < NUM_FFT - 1; k++) begin
                entry_next[k] = entry[k+1];
            end
            entry_next[NUM_FFT-1] = '0;
            count_next = count - (FFT_ID_W+1)'(1);
        end
        for (int i = 0; i < NUM_FFT; i++) begin
            if (accept[i]) begin
                entry_next[count_next[FFT_ID_W-1:0]] = FFT_ID_W'(i);
                count_next      = count_next + (FFT_ID_W+1)'(1);
                pending_next[i] = 1'b1;
            end
        end
    end

    // Queue state registers
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int k = 0; k < NUM_FFT; k++) begin
                entry[k] <= '0;
            end
            count   <= '0;
            pending <= '0;
        end else begin
            entry   <= entry_next;
            count   <= count_next;
            pending <= pending_next;
        end
    end

endmodule
`default_nettype wire

// File: rtl/fft_readout_scheduler.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : fft_readout_scheduler                                        |
// | Description : Drains the four FFT engine result RAMs oldest-first into one |
// |               valid/ready bin stream, then releases each engine buffer.    |
// |               Optional macro OVERRUN_STATS_EN adds overrun_count[7:0].     |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module fft_readout_scheduler
    import fft_sched_pkg::*;
(
    input  wire                        clk,
    input  wire                        reset,
    input  wire  [NUM_FFT-1:0]         fft_done,
    output logic [NUM_FFT-1:0]         fft_rd_en,
    output logic [ADDR_W-1:0]          fft_rd_addr,
    input  wire  [NUM_FFT*DATA_W-1:0]  fft_rd_data,
    output logic [NUM_FFT-1:0]         fft_release,
    fft_readout_scheduler_if.master    out_if,
    output logic                       busy,
    output logic                       overrun
`ifdef OVERRUN_STATS_EN
    ,
    output logic [7:0]                 overrun_count
`endif
);

    localparam logic [ADDR_W:0]   BIN_END  = (ADDR_W+1)'(BIN_COUNT);
    localparam logic [ADDR_W-1:0] LAST_BIN = ADDR_W'(BIN_COUNT - 1);

    state_t              state;
    state_t              state_next;
    logic [FFT_ID_W-1:0] cur_id;
    logic [ADDR_W:0]     bin_cnt;
    logic [ADDR_W-1:0]   addr_hold;
    logic                in_flight;
    logic [ADDR_W-1:0]   in_flight_bin;
    skid_entry_t         skid0;
    skid_entry_t         skid1;
    logic [1:0]          skid_cnt;
    logic [1:0]          room_used;
    logic [SEQ_W-1:0]    frame_seq;
    logic                issue;
    logic                pop;
    logic                queue_pop;
    logic [FFT_ID_W-1:0] q_head;
    logic                q_not_empty;
    logic [NUM_FFT-1:0]  q_dropped;
    logic [DATA_W-1:0]   rd_words [NUM_FFT];
    logic [DATA_W-1:0]   rd_word;
    skid_entry_t         captured;

    fft_order_queue u_queue (
        .clk       (clk),
        .reset     (reset),
        .done      (fft_done),
        .pop       (queue_pop),
        .head_id   (q_head),
        .not_empty (q_not_empty),
        .dropped   (q_dropped)
    );

    generate
        for (genvar g = 0; g < NUM_FFT; g++) begin : g_rd_slice
            assign rd_words[g] = fft_rd_data[g*DATA_W +: DATA_W];
        end
    endgenerate

    assign rd_word  = rd_words[cur_id];
    assign captured = '{bin: in_flight_bin, data: rd_word};

    // Stream side: head of the skid buffer
    assign out_if.out_valid     = (skid_cnt != 2'd0);
    assign out_if.out_data      = skid0.data;
    assign out_if.out_bin       = skid0.bin;
    assign out_if.out_last      = out_if.out_valid && (skid0.bin == LAST_BIN);
    assign out_if.out_fft_id    = cur_id;
    assign out_if.out_frame_seq = frame_seq;

    assign pop  = out_if.out_valid && out_if.out_ready;
    assign busy = (state != S_IDLE) || q_not_empty;

    // A slot freed by this cycle's pop counts as room, which sustains one bin per cycle
    assign room_used = skid_cnt - {1'b0, pop} + {1'b0, in_flight};
    assign issue     = (state == S_READ) && (bin_cnt != BIN_END) && (room_used < 2'd2);

    // Address stays put between issues so the RAM sees no spurious toggles
    assign fft_rd_addr = issue ? bin_cnt[ADDR_W-1:0] : addr_hold;

    // FSM state register
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // FSM next state and strobes
    always_comb begin
        state_next  = state;
        fft_rd_en   = '0;
        fft_release = '0;
        queue_pop   = 1'b0;
        case (state)
            S_IDLE: begin
                if (q_not_empty) begin
                    state_next = S_READ;
                end
            end
            S_READ: begin
                if (issue) begin
                    fft_rd_en[cur_id] = 1'b1;
                end
                if (pop && out_if.out_last) begin
                    state_next = S_RELEASE;
                end
            end
            S_RELEASE: begin
                fft_release[cur_id] = 1'b1;
                queue_pop           = 1'b1;
                state_next          = S_IDLE;
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    // Frame setup, read address counter, in-flight tracking and sequence number
    always_ff @(posedge clk) begin
        if (reset) begin
            cur_id        <= '0;
            bin_cnt       <= '0;
            addr_hold     <= '0;
            in_flight     <= 1'b0;
            in_flight_bin <= '0;
            frame_seq     <= '0;
            overrun       <= 1'b0;
        end else begin
            overrun   <= |q_dropped;
            in_flight <= issue;
            if (state == S_IDLE && q_not_empty) begin
                cur_id  <= q_head;
                bin_cnt <= '0;
            end
            if (issue) begin
                bin_cnt       <= bin_cnt + (ADDR_W+1)'(1);
                addr_hold     <= bin_cnt[ADDR_W-1:0];
                in_flight_bin <= bin_cnt[ADDR_W-1:0];
            end
            if (state == S_RELEASE) begin
                frame_seq <= frame_seq + SEQ_W'(1);
            end
        end
    end

    // Two-entry skid: capture the RAM word the cycle after issue, shift on pop
    always_ff @(posedge clk) begin
        if (reset) begin
            skid0    <= '0;
            skid1    <= '0;
            skid_cnt <= 2'd0;
        end else begin
            case ({pop, in_flight})
                2'b01: begin
                    if (skid_cnt == 2'd0) begin
                        skid0 <= captured;
                    end else begin
                        skid1 <= captured;
                    end
                    skid_cnt <= skid_cnt + 2'd1;
                end
                2'b10: begin
                    skid0    <= skid1;
                    skid_cnt <= skid_cnt - 2'd1;
                end
                2'b11: begin
                    if (skid_cnt == 2'd1) begin
                        skid0 <= captured;
                    end else begin
                        skid0 <= skid1;
                        skid1 <= captured;
                    end
                end
                default: begin
                end
            endcase
        end
    end

`ifdef OVERRUN_STATS_EN
    // Saturating count of dropped dones, cleared only by reset
    always_ff @(posedge clk) begin
        if (reset) begin
            overrun_count <= '0;
        end else begin
            overrun_count <= sat_add8(overrun_count, q_dropped);
        end
    end
`endif

endmodule
`default_nettype wire

// File: tb/tb_fft_readout_scheduler.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_fft_readout_scheduler                                     |
// | Description : Directed bench for fft_readout_scheduler with a behavioural  |
// |               result-RAM model. Honours OVERRUN_STATS_EN when defined.     |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_fft_readout_scheduler;
    import fft_sched_pkg::*;

    logic                       clk = 1'b0;
    logic                       reset;
    logic [NUM_FFT-1:0]         fft_done;
    logic [NUM_FFT-1:0]         fft_rd_en;
    logic [ADDR_W-1:0]          fft_rd_addr;
    logic [NUM_FFT*DATA_W-1:0]  fft_rd_data = '0;
    logic [NUM_FFT-1:0]         fft_release;
    logic                       busy;
    logic                       overrun;
`ifdef OVERRUN_STATS_EN
    logic [7:0]                 overrun_count;
`endif

    int vectors     = 0;
    int miscompares = 0;
    int onehot_viol = 0;
    int hold_viol   = 0;

    fft_readout_scheduler_if sif ();

    fft_readout_scheduler dut (
        .clk         (clk),
        .reset       (reset),
        .fft_done    (fft_done),
        .fft_rd_en   (fft_rd_en),
        .fft_rd_addr (fft_rd_addr),
        .fft_rd_data (fft_rd_data),
        .fft_release (fft_release),
        .out_if      (sif.master),
        .busy        (busy),
        .overrun     (overrun)
`ifdef OVERRUN_STATS_EN
        ,
        .overrun_count (overrun_count)
`endif
    );

    always #5 clk = ~clk;

    // Content of engine id's result RAM at a given bin
    function automatic logic [31:0] ram_word(input int id, input int addr);
        logic [8:0]  a;
        logic [15:0] lo;
        a  = addr[8:0];
        lo = 16'(addr * 3 + id * 7 + 16'h1234);
        return {6'(id), 1'b0, a, lo};
    endfunction

    // Result RAMs: one-cycle read latency per engine
    always @(posedge clk) begin
        for (int i = 0; i < NUM_FFT; i++) begin
            if (fft_rd_en[i]) begin
                fft_rd_data[i*DATA_W +: DATA_W] <= ram_word(i, int'(fft_rd_addr));
            end
        end
    end

    // Read-port hygiene: one-hot strobe, address held while idle
    logic [ADDR_W-1:0] prev_addr = '0;
    logic              prev_rst  = 1'b1;
    always @(negedge clk) begin
        #2;
        if ($countones(fft_rd_en) > 1) onehot_viol++;
        if (!reset && !prev_rst && fft_rd_en == '0 && fft_rd_addr != prev_addr) hold_viol++;
        prev_addr = fft_rd_addr;
        prev_rst  = reset;
    end

    task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Consume one frame (or up to stop_bin), checking every accepted beat and
    // stall stability; optionally inject a done mask at loop iteration inject_at
    task automatic collect_frame(input int exp_id, input int exp_seq, input int ready_pct,
                                 input int inject_at, input logic [3:0] inject_mask, input int stop_bin);
        int          nb;
        int          beat_err;
        int          stall_viol;
        logic        stalled;
        logic        finished;
        logic [31:0] snap_data;
        logic [8:0]  snap_bin;
        nb = 0; beat_err = 0; stall_viol = 0;
        stalled = 1'b0; finished = 1'b0;
        snap_data = '0; snap_bin = '0;
        for (int iter = 0; iter < 6000 && !finished; iter++) begin
            @(negedge clk);
            fft_done = (iter == inject_at) ? inject_mask : 4'b0000;
            if (inject_at >= 0 && iter == inject_at + 1) check_value("overrun_pulse", {31'd0, overrun}, 32'd1);
            if (inject_at >= 0 && iter == inject_at + 2) check_value("overrun_clear", {31'd0, overrun}, 32'd0);
            if (stalled) begin
                if (!sif.out_valid || sif.out_data !== snap_data || sif.out_bin !== snap_bin) stall_viol++;
            end
            sif.out_ready = ($urandom_range(99) < ready_pct);
            stalled   = sif.out_valid && !sif.out_ready;
            snap_data = sif.out_data;
            snap_bin  = sif.out_bin;
            if (sif.out_valid && sif.out_ready) begin
                if (sif.out_bin !== nb[8:0] || sif.out_data !== ram_word(exp_id, nb) ||
                    sif.out_fft_id !== exp_id[1:0] || sif.out_frame_seq !== exp_seq[15:0] ||
                    sif.out_last !== (nb == BIN_COUNT - 1)) beat_err++;
                if (nb == stop_bin || nb == BIN_COUNT - 1) finished = 1'b1;
                nb++;
            end
        end
        fft_done = 4'b0000;
        check_value("bins_accepted", nb, (stop_bin < 0) ? BIN_COUNT : stop_bin + 1);
        check_value("beat_errors", beat_err, 0);
        check_value("stall_stable", stall_viol, 0);
    endtask

    task automatic pulse_done(input logic [3:0] mask);
        @(negedge clk);
        fft_done = mask;
        @(negedge clk);
        fft_done = 4'b0000;
    endtask

    // Overall time limit
    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int rel_seen;
        reset = 1'b1;
        fft_done = 4'b0000;
        sif.out_ready = 1'b0;
        repeat (3) @(negedge clk);
        check_value("rst_valid",   {31'd0, sif.out_valid}, 32'd0);
        check_value("rst_rd_en",   {28'd0, fft_rd_en}, 32'd0);
        check_value("rst_release", {28'd0, fft_release}, 32'd0);
        check_value("rst_busy",    {31'd0, busy}, 32'd0);
        check_value("rst_overrun", {31'd0, overrun}, 32'd0);
        check_value("rst_seq",     {16'd0, sif.out_frame_seq}, 32'd0);
        check_value("rst_data",    sif.out_data, 32'd0);
        reset = 1'b0;

        // 1: single frame from engine 0, continuous ready
        pulse_done(4'b0001);
        check_value("t1_busy", {31'd0, busy}, 32'd1);
        collect_frame(0, 0, 100, -1, 4'b0000, -1);
        @(negedge clk);
        check_value("t1_release", {28'd0, fft_release}, 32'h1);
        @(negedge clk);
        check_value("t1_release_end", {28'd0, fft_release}, 32'h0);
        check_value("t1_seq", {16'd0, sif.out_frame_seq}, 32'd1);
        check_value("t1_idle", {31'd0, busy}, 32'd0);

        // 2: engines 1 and 3 done together -> ID order, 2-cycle gap
        pulse_done(4'b1010);
        collect_frame(1, 1, 100, -1, 4'b0000, -1);
        @(negedge clk);
        check_value("t2_release1", {28'd0, fft_release}, 32'h2);
        check_value("t2_gap1", {28'd0, fft_rd_en}, 32'h0);
        @(negedge clk);
        check_value("t2_gap2", {28'd0, fft_rd_en}, 32'h0);
        @(negedge clk);
        check_value("t2_next_rd_en", {28'd0, fft_rd_en}, 32'h8);
        collect_frame(3, 2, 100, -1, 4'b0000, -1);
        @(negedge clk);
        check_value("t2_release3", {28'd0, fft_release}, 32'h8);
        @(negedge clk);
        check_value("t2_seq", {16'd0, sif.out_frame_seq}, 32'd3);

        // 3: 30% ready, then a done landing on the release cycle is a new frame
        pulse_done(4'b0001);
        collect_frame(0, 3, 30, -1, 4'b0000, -1);
        @(negedge clk);
        check_value("t3_release", {28'd0, fft_release}, 32'h1);
        fft_done = 4'b0001;
        @(negedge clk);
        fft_done = 4'b0000;
        check_value("t3_done_at_release_no_overrun", {31'd0, overrun}, 32'd0);
        check_value("t3_requeued_busy", {31'd0, busy}, 32'd1);
        check_value("t3_seq", {16'd0, sif.out_frame_seq}, 32'd4);
        collect_frame(0, 4, 100, -1, 4'b0000, -1);
        repeat (2) @(negedge clk);

        // 4: repeated done for the engine being read -> overrun, single frame
        pulse_done(4'b0100);
        collect_frame(2, 5, 100, 100, 4'b0100, -1);
        @(negedge clk);
        check_value("t4_release", {28'd0, fft_release}, 32'h4);
        repeat (6) @(negedge clk);
        check_value("t4_single_frame_busy", {31'd0, busy}, 32'd0);
        check_value("t4_single_frame_valid", {31'd0, sif.out_valid}, 32'd0);
        check_value("t4_seq", {16'd0, sif.out_frame_seq}, 32'd6);
`ifdef OVERRUN_STATS_EN
        check_value("t4_overrun_count", {24'd0, overrun_count}, 32'd1);
`endif

        // 5: reset at bin 200 aborts the frame without a release
        pulse_done(4'b0001);
        collect_frame(0, 6, 100, -1, 4'b0000, 200);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check_value("t5_valid", {31'd0, sif.out_valid}, 32'd0);
        check_value("t5_busy", {31'd0, busy}, 32'd0);
        check_value("t5_seq", {16'd0, sif.out_frame_seq}, 32'd0);
        rel_seen = 0;
        for (int c = 0; c < 20; c++) begin
            if (fft_release != 4'b0000) rel_seen++;
            @(negedge clk);
        end
        check_value("t5_no_release", rel_seen, 0);
`ifdef OVERRUN_STATS_EN
        check_value("t5_count_cleared", {24'd0, overrun_count}, 32'd0);
`endif
        pulse_done(4'b0001);
        collect_frame(0, 0, 100, -1, 4'b0000, -1);
        repeat (2) @(negedge clk);
        check_value("t5_seq_after", {16'd0, sif.out_frame_seq}, 32'd1);

        // 6: sequence wrap via preloaded counter
        force dut.frame_seq = 16'hFFFF;
        @(negedge clk);
        release dut.frame_seq;
        @(negedge clk);
        check_value("t6_preload", {16'd0, sif.out_frame_seq}, 32'h0000FFFF);
        pulse_done(4'b0010);
        collect_frame(1, 32'h0000FFFF, 100, -1, 4'b0000, -1);
        repeat (2) @(negedge clk);
        check_value("t6_seq_wrap", {16'd0, sif.out_frame_seq}, 32'd0);

        check_value("rd_en_onehot", onehot_viol, 0);
        check_value("rd_addr_hold", hold_viol, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire
